interp_dual_ch: RTL and testbench

Dual-channel linear interpolator for the TX sample path: it upsamples paired I/Q (or two-antenna) sample streams by 2^LOG2_INTERP_LEN, producing one output pair per DAC-side `out_strobe`. It is the transmit-side counterpart of the RX moving-average smoother. Input samples arrive on a valid/ready handshake from the baseband. Output is paced entirely by `out_strobe`; the block never stalls the DAC side and holds the last sample on input underrun.

---
 rtl/interp_dual_ch.sv | 224 ++++++++++++++++++++++
 tb/tb_interp_dual_ch.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/interp_dual_ch.sv
`default_nettype none
// ============================================================================
//  Module      : interp_dual_ch
//  Description : Dual-channel linear interpolator for the TX sample path.
//                Upsamples paired signed samples by N = 2^LOG2_INTERP_LEN.
//                Produces one output pair per out_strobe tick. When input
//                runs dry, the block holds the last sample.
//  Ports       : clk, rstn (sync, active-low)
//                data_in0/1, data_in_valid, data_in_ready  - input handshake
//                out_strobe                                - output-rate tick
//                data_out0/1, data_out_valid, underrun     - registered outputs
//  Options     : INTERP_DUAL_CH_ROUND_EN - round-half-up output instead of
//                floor truncation.
//  Revision    : 1.0 - initial release
// ============================================================================
module interp_dual_ch #(
    parameter int DATA_WIDTH0     = 16,
    parameter int DATA_WIDTH1     = 16,
    parameter int LOG2_INTERP_LEN = 2
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic signed [DATA_WIDTH0-1:0] data_in0,
    input  logic signed [DATA_WIDTH1-1:0] data_in1,
    input  logic                          data_in_valid,
    output logic                          data_in_ready,
    input  logic                          out_strobe,
    output logic signed [DATA_WIDTH0-1:0] data_out0,
    output logic signed [DATA_WIDTH1-1:0] data_out1,
    output logic                          data_out_valid,
    output logic                          underrun
);

    localparam int L   = LOG2_INTERP_LEN;
    localparam int DW0 = DATA_WIDTH0 + 1;
    localparam int DW1 = DATA_WIDTH1 + 1;
    localparam int AW0 = DATA_WIDTH0 + L + 1;
    localparam int AW1 = DATA_WIDTH1 + L + 1;
    localparam logic [L-1:0] K_LAST = {L{1'b1}};

`ifdef INTERP_DUAL_CH_ROUND_EN
    // Half an output LSB in accumulator units gives round-half-up.
    localparam logic signed [AW0-1:0] RND0 = AW0'(1) <<< (L - 1);
    localparam logic signed [AW1-1:0] RND1 = AW1'(1) <<< (L - 1);
`else
    localparam logic signed [AW0-1:0] RND0 = '0;
    localparam logic signed [AW1-1:0] RND1 = '0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic signed [DATA_WIDTH0-1:0] c0_s0_q, c0_s0_d, c0_s1_q, c0_s1_d;
    logic signed [DATA_WIDTH0-1:0] c0_pend_q, c0_pend_d, c0_out_q, c0_out_d;
    logic signed [DW0-1:0]         c0_delta_q, c0_delta_d;
    logic signed [AW0-1:0]         c0_acc_q, c0_acc_d;

    logic signed [DATA_WIDTH1-1:0] c1_s0_q, c1_s0_d, c1_s1_q, c1_s1_d;
    logic signed [DATA_WIDTH1-1:0] c1_pend_q, c1_pend_d, c1_out_q, c1_out_d;
    logic signed [DW1-1:0]         c1_delta_q, c1_delta_d;
    logic signed [AW1-1:0]         c1_acc_q, c1_acc_d;

    logic         pend_vld_q, pend_vld_d;
    logic [L-1:0] k_q, k_d;
    logic         vld_q, vld_d;
    logic         unr_q, unr_d;

    // Ready depends on registers only, so there is no combinational
    // path from data_in_valid back to data_in_ready.
    assign data_in_ready = (state_q != S_RUN) | ~pend_vld_q;

    logic xfer;
    assign xfer = data_in_valid & data_in_ready;

    // Samples scaled into accumulator units (value * N).
    logic signed [AW0-1:0] c0_s0_acc, c0_s1_acc, c0_sum;
    logic signed [AW1-1:0] c1_s0_acc, c1_s1_acc, c1_sum;
    assign c0_s0_acc = AW0'(c0_s0_q) <<< L;
    assign c0_s1_acc = AW0'(c0_s1_q) <<< L;
    assign c1_s0_acc = AW1'(c1_s0_q) <<< L;
    assign c1_s1_acc = AW1'(c1_s1_q) <<< L;
    assign c0_sum    = c0_acc_q + RND0;
    assign c1_sum    = c1_acc_q + RND1;

    // Segment slopes, one bit wider than the samples so full-scale swings fit.
    logic signed [DW0-1:0] c0_fill_delta, c0_next_delta;
    logic signed [DW1-1:0] c1_fill_delta, c1_next_delta;
    assign c0_fill_delta = DW0'(data_in0)  - DW0'(c0_s0_q);
    assign c1_fill_delta = DW1'(data_in1)  - DW1'(c1_s0_q);
    assign c0_next_delta = DW0'(c0_pend_q) - DW0'(c0_s1_q);
    assign c1_next_delta = DW1'(c1_pend_q) - DW1'(c1_s1_q);

    always_comb begin
        state_d    = state_q;
        c0_s0_d    = c0_s0_q;
        c0_s1_d    = c0_s1_q;
        c0_pend_d  = c0_pend_q;
        c0_delta_d = c0_delta_q;
        c0_acc_d   = c0_acc_q;
        c0_out_d   = c0_out_q;
        c1_s0_d    = c1_s0_q;
        c1_s1_d    = c1_s1_q;
        c1_pend_d  = c1_pend_q;
        c1_delta_d = c1_delta_q;
        c1_acc_d   = c1_acc_q;
        c1_out_d   = c1_out_q;
        pend_vld_d = pend_vld_q;
        k_d        = k_q;
        vld_d      = 1'b0;
        unr_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    c0_s0_d = data_in0;
                    c1_s0_d = data_in1;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (xfer) begin
                    c0_s1_d    = data_in0;
                    c1_s1_d    = data_in1;
                    c0_acc_d   = c0_s0_acc;
                    c1_acc_d   = c1_s0_acc;
                    c0_delta_d = c0_fill_delta;
                    c1_delta_d = c1_fill_delta;
                    k_d        = '0;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                // Ready implies pend is empty, so a transfer never collides
                // with the segment end that drains pend.
                if (xfer) begin
                    c0_pend_d  = data_in0;
                    c1_pend_d  = data_in1;
                    pend_vld_d = 1'b1;
                end
                if (out_strobe) begin
                    vld_d    = 1'b1;
                    c0_out_d = DATA_WIDTH0'(c0_sum >>> L);
                    c1_out_d = DATA_WIDTH1'(c1_sum >>> L);
                    if (k_q == K_LAST) begin
                        k_d      = '0;
                        c0_s0_d  = c0_s1_q;
                        c1_s0_d  = c1_s1_q;
                        c0_acc_d = c0_s1_acc;
                        c1_acc_d = c1_s1_acc;
                        if (pend_vld_q) begin
                            c0_s1_d    = c0_pend_q;
                            c1_s1_d    = c1_pend_q;
                            c0_delta_d = c0_next_delta;
                            c1_delta_d = c1_next_delta;
                            pend_vld_d = 1'b0;
                        end else begin
                            // Flat segment: keep emitting the last sample.
                            c0_delta_d = '0;
                            c1_delta_d = '0;
                            unr_d      = 1'b1;
                        end
                    end else begin
                        c0_acc_d = c0_acc_q + AW0'(c0_delta_q);
                        c1_acc_d = c1_acc_q + AW1'(c1_delta_q);
                        k_d      = k_q + L'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            c0_s0_q    <= '0;
            c0_s1_q    <= '0;
            c0_pend_q  <= '0;
            c0_delta_q <= '0;
            c0_acc_q   <= '0;
            c0_out_q   <= '0;
            c1_s0_q    <= '0;
            c1_s1_q    <= '0;
            c1_pend_q  <= '0;
            c1_delta_q <= '0;
            c1_acc_q   <= '0;
            c1_out_q   <= '0;
            pend_vld_q <= 1'b0;
            k_q        <= '0;
            vld_q      <= 1'b0;
            unr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            c0_s0_q    <= c0_s0_d;
            c0_s1_q    <= c0_s1_d;
            c0_pend_q  <= c0_pend_d;
            c0_delta_q <= c0_delta_d;
            c0_acc_q   <= c0_acc_d;
            c0_out_q   <= c0_out_d;
            c1_s0_q    <= c1_s0_d;
            c1_s1_q    <= c1_s1_d;
            c1_pend_q  <= c1_pend_d;
            c1_delta_q <= c1_delta_d;
            c1_acc_q   <= c1_acc_d;
            c1_out_q   <= c1_out_d;
            pend_vld_q <= pend_vld_d;
            k_q        <= k_d;
            vld_q      <= vld_d;
            unr_q      <= unr_d;
        end
    end

    assign data_out0      = c0_out_q;
    assign data_out1      = c1_out_q;
    assign data_out_valid = vld_q;
    assign underrun       = unr_q;

endmodule
`default_nettype wire

// File: tb/tb_interp_dual_ch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_interp_dual_ch
//  Description : Self-checking bench for interp_dual_ch (L=2, N=4).
//                Single-segment vectors from a table, plus directed
//                sequences for ramp, underrun, backpressure, boundary
//                collision and mid-run reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_interp_dual_ch;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic signed [15:0] data_in0 = '0;
    logic signed [15:0] data_in1 = '0;
    logic               data_in_valid = 1'b0;
    logic               data_in_ready;
    logic               out_strobe = 1'b0;
    logic signed [15:0] data_out0;
    logic signed [15:0] data_out1;
    logic               data_out_valid;
    logic               underrun;

    int total = 0;
    int bad   = 0;

    interp_dual_ch #(
        .DATA_WIDTH0    (16),
        .DATA_WIDTH1    (16),
        .LOG2_INTERP_LEN(2)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .data_in0      (data_in0),
        .data_in1      (data_in1),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .out_strobe    (out_strobe),
        .data_out0     (data_out0),
        .data_out1     (data_out1),
        .data_out_valid(data_out_valid),
        .underrun      (underrun)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic signed [15:0] a0, a1, b0, b1;
        logic [0:3][15:0]   e0, e1;
    } vec_t;

    function automatic vec_t mk(input int a0, input int a1, input int b0, input int b1,
                                input int e00, input int e01, input int e02, input int e03,
                                input int e10, input int e11, input int e12, input int e13);
        vec_t v;
        v.a0 = 16'(a0); v.a1 = 16'(a1); v.b0 = 16'(b0); v.b1 = 16'(b1);
        v.e0[0] = 16'(e00); v.e0[1] = 16'(e01); v.e0[2] = 16'(e02); v.e0[3] = 16'(e03);
        v.e1[0] = 16'(e10); v.e1[1] = 16'(e11); v.e1[2] = 16'(e12); v.e1[3] = 16'(e13);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0; out_strobe = 1'b0; data_in_valid = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic check_reset_state(input string nm);
        chk({nm, "_o0"}, data_out0, 0);
        chk({nm, "_o1"}, data_out1, 0);
        chk({nm, "_vld"}, data_out_valid, 0);
        chk({nm, "_unr"}, underrun, 0);
        chk({nm, "_rdy"}, data_in_ready, 1);
    endtask

    // Present one pair and hold it until it is accepted (bounded wait).
    task automatic push(input int a, input int b);
        int n = 0;
        data_in0 = 16'(a); data_in1 = 16'(b); data_in_valid = 1'b1;
        while (!data_in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("push_ready_timeout", data_in_ready, 1);
        tick();
        data_in_valid = 1'b0;
    endtask

    task automatic strobe(input string nm, input int e0, input int e1, input int eu);
        out_strobe = 1'b1;
        tick();
        out_strobe = 1'b0;
        chk({nm, "_vld"}, data_out_valid, 1);
        chk({nm, "_o0"}, data_out0, e0);
        chk({nm, "_o1"}, data_out1, e1);
        chk({nm, "_unr"}, underrun, eu);
    endtask

    task automatic strobe_none(input string nm);
        out_strobe = 1'b1;
        tick();
        out_strobe = 1'b0;
        chk({nm, "_vld"}, data_out_valid, 0);
        chk({nm, "_unr"}, underrun, 0);
    endtask

    vec_t vt[4];

    initial begin
        vt[0] = mk(0, 100, 100, 0,   0, 25, 50, 75,   100, 75, 50, 25);
        vt[3] = mk(1, -1, 2, -2,
`ifdef INTERP_DUAL_CH_ROUND_EN
                   1, 1, 2, 2,   -1, -1, -1, -2);
`else
                   1, 1, 1, 1,   -1, -2, -2, -2);
`endif
`ifdef INTERP_DUAL_CH_ROUND_EN
        vt[1] = mk(-8, 32767, 5, -32768,   -8, -5, -1, 2,   32767, 16383, 0, -16384);
        vt[2] = mk(-32768, 7, 32767, 7,   -32768, -16384, 0, 16383,   7, 7, 7, 7);
`else
        vt[1] = mk(-8, 32767, 5, -32768,   -8, -5, -2, 1,   32767, 16383, -1, -16385);
        vt[2] = mk(-32768, 7, 32767, 7,   -32768, -16385, -1, 16383,   7, 7, 7, 7);
`endif

        // Reset values
        do_reset();
        check_reset_state("rst");

        // Single-segment table
        for (int v = 0; v < 4; v++) begin
            do_reset();
            strobe_none($sformatf("v%0d_idle", v));
            push(int'(vt[v].a0), int'(vt[v].a1));
            strobe_none($sformatf("v%0d_fill", v));
            push(int'(vt[v].b0), int'(vt[v].b1));
            for (int j = 0; j < 4; j++)
                strobe($sformatf("v%0d_s%0d", v, j), int'($signed(vt[v].e0[j])),
                       int'($signed(vt[v].e1[j])), (j == 3) ? 1 : 0);
            tick();
            chk($sformatf("v%0d_pulse", v), data_out_valid, 0);
        end

        // Ramp with a strobe every third cycle
        do_reset();
        push(0, 0); push(100, 0); push(200, 0);
        for (int i = 0; i < 8; i++) begin
            strobe($sformatf("ramp%0d", i), 25 * i, 0, 0);
            if (i == 3) begin
                push(300, 0);
                tick();
            end else begin
                tick();
                tick();
            end
        end

        // Underrun hold and resume
        do_reset();
        push(0, 0); push(400, -400);
        for (int i = 1; i <= 16; i++) begin
            int e;
            if (i == 9) push(800, -800);
            e = (i <= 4) ? 100 * (i - 1) : (i <= 12) ? 400 : 400 + 100 * (i - 13);
            strobe($sformatf("unr%0d", i), e, -e, (i == 4 || i == 8 || i == 16) ? 1 : 0);
        end

        // Backpressure: valid held high continuously, strobe every cycle
        do_reset();
        push(0, 5); push(100, 5);
        begin
            int src = 2;
            data_in0 = 16'(200); data_in1 = 16'(5); data_in_valid = 1'b1;
            for (int i = 1; i <= 20; i++) begin
                logic xf;
                int e;
                xf = data_in_valid & data_in_ready;
                e  = (i <= 16) ? 25 * (i - 1) : 400;
                strobe($sformatf("bp%0d", i), e, 5, (i == 16 || i == 20) ? 1 : 0);
                chk($sformatf("bp%0d_rdy", i), data_in_ready,
                    ((i % 4) == 0 || i >= 12) ? 1 : 0);
                if (xf) begin
                    src++;
                    if (src <= 4) data_in0 = 16'(100 * src);
                    else data_in_valid = 1'b0;
                end
            end
            data_in_valid = 1'b0;
        end

        // Input arriving on the segment-end strobe with pend empty
        do_reset();
        push(0, 0); push(100, 0);
        for (int i = 1; i <= 12; i++) begin
            int e;
            if (i == 4) begin
                data_in0 = 16'(200); data_in1 = 16'(0); data_in_valid = 1'b1;
            end
            e = (i <= 4) ? 25 * (i - 1) : (i <= 8) ? 100 : 100 + 25 * (i - 9);
            strobe($sformatf("col%0d", i), e, 0, (i == 4 || i == 12) ? 1 : 0);
            data_in_valid = 1'b0;
        end

        // Reset in the middle of a segment
        do_reset();
        push(10, 20); push(50, 60); push(90, 100);
        strobe("mr0", 10, 20, 0);
        strobe("mr1", 20, 30, 0);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check_reset_state("mr_rst");
        strobe_none("mr_idle");
        push(500, -500);
        strobe_none("mr_fill");
        push(600, -600);
        strobe("mr_first", 500, -500, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
